dbg_print_fmt: RTL
==================

// Module: dbg_print_fmt
// PURPOSE
//  Hardware replacement for the host-only debug_dump() printf path.
//  Accepts one binary value and emits the byte stream "Hello World <decimal>\n".
//  Output is a valid/ready byte stream sitting directly upstream of uart_tx.
//  Decimal text has no leading zeros; a value of 0 prints "0".
// PARAMETERS
//  WIDTH    32  bit width of start_value
//  NDIGITS  10  BCD digits held; must be >= ceil(WIDTH*log10(2)) (10 for 32b)
// PORTS
//  clock        in   1      single clock, all state on rising edge
//  reset        in   1      asynchronous, active-high; clears all state
//  start_valid  in   1      request to print start_value
//  start_ready  out  1      high only in IDLE
//  start_value  in   WIDTH  unsigned value to print, sampled on accept
//  out_data     out  8      ASCII byte
//  out_valid    out  1      out_data is valid
//  out_ready    in   1      downstream (uart_tx) accepts byte
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, start_ready=1, busy=0, out_valid=0, out_data=8'h00.
//  - reset is async: out_valid drops without waiting for a clock edge.
//  Accept: start_valid&&start_ready at edge E latches start_value, goes to CONVERT.
//  CONVERT: double-dabble, one shift per cycle, exactly WIDTH cycles.
//  - On the last shift, latch first_idx = index of the most-significant nonzero digit.
//  - first_idx=0 when the value is 0.
//  PREFIX: emit "Hello World " (12 bytes, ends in 0x20) from a constant ROM.
//  - First out_valid appears in cycle WIDTH+1 after E.
//  DIGITS: emit ASCII '0'+bcd[i] for i = first_idx down to 0.
//  NL: emit 8'h0A, then go to IDLE. start_ready is high on the next cycle.
//  Handshake:
//  - A byte transfers on out_valid&&out_ready.
//  - The index advances only on a transfer.
//  - While out_valid&&!out_ready, out_data and out_valid hold stable.
//  - out_valid never drops without a transfer, except on reset.
//  - Back-to-back bytes are allowed: out_valid stays high across PREFIX->DIGITS->NL.
//  Total bytes per message = 12 + (first_idx+1) + 1.
//  Minimum latency from accept to the final byte (out_ready=1) = WIDTH + 14 + first_idx cycles.
//  start_valid while busy: ignored, not queued; start_ready=0.
//  BCD add-3 rule: a digit >=5 gets +3 before each shift.
//  - Digits are 4 bits wide, with no overflow for WIDTH<=32/NDIGITS=10.
//  Reset in any state: returns to IDLE, the partial message is dropped, and nothing resumes.
// STRUCTURE
//  Package dbg_fmt_pkg holds:
//  - the state enum {IDLE, CONVERT, PREFIX, DIGITS, NL}
//  - PREFIX_LEN=12 and the PREFIX_ROM byte array
//  - ASCII_0=8'h30 and ASCII_NL=8'h0A
//  Sub-module dbg_bcd_conv (WIDTH, NDIGITS):
//  - load/shift interface, done pulse, bcd[NDIGITS*4-1:0] output, first_idx output.
//  The top level holds the FSM, the byte index counter, and the output mux/register.
// TESTING
//  1 value=1234, out_ready=1:
//    "Hello World 1234\n" (17 bytes); first out_valid at cycle 33 after accept.
//  2 value=0: "Hello World 0\n" (14 bytes); digit byte is 8'h30.
//  3 value=32'hFFFFFFFF: "Hello World 4294967295\n" (23 bytes).
//  4 value=1000, out_ready random 50%: same bytes as the ideal case.
//    - out_data stable across every stall; no byte lost or duplicated.
//  5 start_valid held high for 200 cycles with value=7:
//    - exactly one "Hello World 7\n"; start_ready=0 throughout busy.
//  6 reset pulse while emitting digit 2 of value 98765:
//    - out_valid=0 before the next edge.
//    - A new start with value=5 yields exactly "Hello World 5\n".

Source files
------------

// File: rtl/dbg_print_fmt_pkg.sv
// Shared definitions for the debug print formatter.
//   state_t     : formatter FSM states
//   PREFIX_LEN  : length of the constant "Hello World " prefix
//   PREFIX_ROM  : prefix bytes, emitted in index order
//   ASCII_0     : base added to a BCD digit to make its ASCII character
//   ASCII_NL    : line terminator byte
package dbg_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    PREFIX,
    DIGITS,
    NL
  } state_t;

  localparam int PREFIX_LEN = 12;

  localparam logic [7:0] PREFIX_ROM [PREFIX_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
    8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h20
  };

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_NL = 8'h0A;

endpackage

// File: rtl/dbg_print_fmt_if.sv
// Request/stream bundle for the debug print formatter.
//   start_valid/start_ready/start_value : request to print one value
//   out_data/out_valid/out_ready        : ASCII byte stream toward uart_tx
// master: the requester / stream consumer side
// slave : the formatter side
interface dbg_print_fmt_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] start_value;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start_valid, start_value, out_ready,
    input  start_ready, out_data, out_valid
  );

  modport slave (
    input  start_valid, start_value, out_ready,
    output start_ready, out_data, out_valid
  );
endinterface

// File: rtl/dbg_print_fmt_bcd_conv.sv
// Serial binary-to-BCD converter (double dabble), one shift per cycle.
//   clock, reset : clock and asynchronous active-high reset
//   load         : capture value and clear the BCD accumulator
//   shift        : perform one add-3/shift step
//   value        : binary input, captured on load
//   done         : high during the cycle whose shift is the last one
//   bcd          : NDIGITS packed 4-bit digits, digit 0 in the low nibble
//   first_idx    : index of the most-significant nonzero digit (0 for value 0)
module dbg_bcd_conv #(
  parameter int WIDTH   = 32,
  parameter int NDIGITS = 10,
  localparam int FI_W   = $clog2(NDIGITS),
  localparam int CNT_W  = $clog2(WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [WIDTH-1:0]     value,
  output logic                 done,
  output logic [4*NDIGITS-1:0] bcd,
  output logic [FI_W-1:0]      first_idx
);

  logic [WIDTH-1:0]     bin_q;
  logic [4*NDIGITS-1:0] bcd_q;
  logic [4*NDIGITS-1:0] bcd_adj;
  logic [4*NDIGITS-1:0] bcd_next;
  logic [CNT_W-1:0]     cnt_q;
  logic [FI_W-1:0]      fi_q;

  function automatic logic [FI_W-1:0] msd(input logic [4*NDIGITS-1:0] b);
    msd = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (b[i*4 +: 4] != 4'd0) msd = FI_W'(i);
    end
  endfunction

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                      : bcd_q[i*4 +: 4];
    end
    bcd_next = {bcd_adj[4*NDIGITS-2:0], bin_q[WIDTH-1]};
  end

  assign done      = shift && (cnt_q == CNT_W'(WIDTH-1));
  assign bcd       = bcd_q;
  assign first_idx = fi_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      fi_q  <= '0;
    end else if (load) begin
      bin_q <= value;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (shift) begin
      bin_q <= bin_q << 1;
      bcd_q <= bcd_next;
      cnt_q <= cnt_q + 1'b1;
      // Leading-digit search looks at the final digits, not the stale register.
      if (done) fi_q <= msd(bcd_next);
    end
  end

endmodule

// File: rtl/dbg_print_fmt.sv
// Formats one unsigned value as "Hello World <decimal>\n" on a byte stream.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : request handshake (start_*) and byte stream (out_*)
//   busy         : high in every state except IDLE
// Outputs are decoded from the registered state and byte index, so they hold
// stable while the downstream stalls and drop immediately on reset.
module dbg_print_fmt
  import dbg_fmt_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NDIGITS = 10
) (
  input  logic           clock,
  input  logic           reset,
  dbg_print_fmt_if.slave bus,
  output logic           busy
);

  localparam int FI_W  = $clog2(NDIGITS);
  localparam int IDX_W = $clog2((PREFIX_LEN > NDIGITS) ? PREFIX_LEN : NDIGITS);
  localparam logic [IDX_W-1:0] PREFIX_LAST = IDX_W'(PREFIX_LEN - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic                   accept;
  logic                   xfer;
  logic                   conv_done;
  logic [4*NDIGITS-1:0]   conv_bcd;
  logic [FI_W-1:0]        conv_first;
  logic [3:0]             digit;

  assign accept = bus.start_valid && (state_q == IDLE);
  assign xfer   = bus.out_valid && bus.out_ready;
  assign digit  = conv_bcd[idx_q*4 +: 4];

  dbg_bcd_conv #(
    .WIDTH   (WIDTH),
    .NDIGITS (NDIGITS)
  ) u_conv (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .shift     (state_q == CONVERT),
    .value     (bus.start_value),
    .done      (conv_done),
    .bcd       (conv_bcd),
    .first_idx (conv_first)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONVERT;
      CONVERT: if (conv_done) state_d = PREFIX;
      PREFIX:  if (xfer && idx_q == PREFIX_LAST) state_d = DIGITS;
      DIGITS:  if (xfer && idx_q == '0) state_d = NL;
      NL:      if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One index serves both phases: counts up through the prefix ROM, then
  // counts down from the leading digit to digit 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      case (state_q)
        CONVERT: idx_q <= '0;
        PREFIX:
          if (xfer) begin
            if (idx_q == PREFIX_LAST) idx_q <= IDX_W'(conv_first);
            else                      idx_q <= idx_q + 1'b1;
          end
        DIGITS:  if (xfer && idx_q != '0) idx_q <= idx_q - 1'b1;
        default: idx_q <= idx_q;
      endcase
    end
  end

  always_comb begin
    bus.start_ready = (state_q == IDLE);
    busy            = (state_q != IDLE);
    bus.out_valid   = 1'b0;
    bus.out_data    = 8'h00;
    case (state_q)
      PREFIX: begin
        bus.out_valid = 1'b1;
        bus.out_data  = PREFIX_ROM[idx_q];
      end
      DIGITS: begin
        bus.out_valid = 1'b1;
        bus.out_data  = ASCII_0 + {4'h0, digit};
      end
      NL: begin
        bus.out_valid = 1'b1;
        bus.out_data  = ASCII_NL;
      end
      default: ;
    endcase
  end

endmodule
